mux_reg_n: RTL and testbench

Parametrised N-input, W-bit selector fused with a configurable-depth pipeline register. It generalises the fixed 4:1 32-bit combinational select used on the PC-source and forwarding paths of the pipelined CPU. It adds pipeline-register semantics: valid tracking, stall (hold), flush (bubble insertion), and detection of out-of-range selects. It sits wherever a selected operand feeds a pipeline boundary, e.g. next-PC selection into IF or forwarded operands into EX.

---
 rtl/mux_reg_n.sv | 93 +++++++++
 tb/tb_mux_reg_n.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_reg_n.sv
// rtl/mux_reg_n.sv - N-input W-bit selector feeding a DEPTH-stage pipeline register
// with valid tracking, stall, flush and out-of-range select detection.
module mux_reg_n #(
   parameter int                WIDTH     = 32,
   parameter int                NUM_IN    = 4,
   parameter int                SEL_W     = $clog2(NUM_IN),
   parameter int                DEPTH     = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_IN*WIDTH-1:0]   data_i,
   input  logic [SEL_W-1:0]          select_i,
   input  logic                      valid_i,
   input  logic                      stall_i,
   input  logic                      flush_i,
   output logic [WIDTH-1:0]          data_o,
   output logic                      valid_o,
   output logic                      sel_err_o
);

   // A power-of-two input count leaves no unused select codes.
   localparam bit SEL_DENSE = ((1 << SEL_W) == NUM_IN);

   logic [WIDTH-1:0] sel_data;
   logic             sel_bad;

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [DEPTH-1:0] err_q;
   logic [DEPTH-1:0] err_d;

   always_comb begin
      sel_data = RESET_VAL;
      for (int k = 0; k < NUM_IN; k++) begin
         if (select_i == SEL_W'(k)) begin
            sel_data = data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   generate
      if (SEL_DENSE) begin : g_dense
         assign sel_bad = 1'b0;
      end else begin : g_sparse
         assign sel_bad = (select_i >= SEL_W'(NUM_IN));
      end
   endgenerate

   // Flush wins over stall; a stalled cycle drops the presented entry.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      if (flush_i) begin
         for (int s = 0; s < DEPTH; s++) begin
            data_d[s] = RESET_VAL;
         end
         valid_d = '0;
         err_d   = '0;
      end else if (!stall_i) begin
         data_d[0]  = sel_data;
         valid_d[0] = valid_i;
         err_d[0]   = sel_bad & valid_i;
         for (int s = 1; s < DEPTH; s++) begin
            data_d[s]  = data_q[s-1];
            valid_d[s] = valid_q[s-1];
            err_d[s]   = err_q[s-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < DEPTH; s++) begin
            data_q[s] <= RESET_VAL;
         end
         valid_q <= '0;
         err_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign data_o    = data_q[DEPTH-1];
   assign valid_o   = valid_q[DEPTH-1];
   assign sel_err_o = err_q[DEPTH-1];

endmodule

// File: tb/tb_mux_reg_n.sv
// tb/tb_mux_reg_n.sv - self-checking bench for mux_reg_n across four configurations
// against an entry-list reference model.
module tb_mux_reg_n;

   logic        clk = 1'b0;
   logic        rst, valid, stall, flush;
   logic [3:0]  sel;
   logic [63:0] in_word [16];

   logic [127:0]  da, db;
   logic [95:0]   dc;
   logic [1023:0] dd;

   logic [31:0] oa, ob, oc;
   logic [63:0] od;
   logic        va, vb, vc, vd, ea, eb, ec, ed;

   int total = 0;
   int bad   = 0;

   // instance configs: 0=A (4x32,D1) 1=B (4x32,D3) 2=C (3x32,D2) 3=D (16x64,D4)
   int          cfg_depth [4] = '{1, 3, 2, 4};
   int          cfg_num   [4] = '{4, 4, 3, 16};
   int          cfg_selw  [4] = '{2, 2, 2, 4};
   int          cfg_w     [4] = '{32, 32, 32, 64};
   logic [63:0] cfg_rv    [4] = '{64'h0, 64'hA5A5A5A5, 64'h13, 64'hFFFF0000FFFF0000};

   // model: per instance, list of entries ordered youngest (0) to oldest
   logic [63:0] m_d [4][4];
   bit          m_v [4][4];
   bit          m_e [4][4];

   logic [63:0] obs_d [4];
   logic        obs_v [4];
   logic        obs_e [4];

   always #5 clk = ~clk;

   always_comb begin
      da = '0;
      db = '0;
      dc = '0;
      dd = '0;
      for (int k = 0; k < 4; k++) begin
         da[k*32 +: 32] = in_word[k][31:0];
         db[k*32 +: 32] = in_word[k][31:0];
      end
      for (int k = 0; k < 3; k++) dc[k*32 +: 32] = in_word[k][31:0];
      for (int k = 0; k < 16; k++) dd[k*64 +: 64] = in_word[k];
   end

   always_comb begin
      obs_d[0] = {32'h0, oa}; obs_v[0] = va; obs_e[0] = ea;
      obs_d[1] = {32'h0, ob}; obs_v[1] = vb; obs_e[1] = eb;
      obs_d[2] = {32'h0, oc}; obs_v[2] = vc; obs_e[2] = ec;
      obs_d[3] = od;          obs_v[3] = vd; obs_e[3] = ed;
   end

   mux_reg_n #(.WIDTH(32), .NUM_IN(4), .DEPTH(1), .RESET_VAL(32'h0)) u_a (
      .clk_i(clk), .rst_i(rst), .data_i(da), .select_i(sel[1:0]), .valid_i(valid),
      .stall_i(stall), .flush_i(flush), .data_o(oa), .valid_o(va), .sel_err_o(ea));
   mux_reg_n #(.WIDTH(32), .NUM_IN(4), .DEPTH(3), .RESET_VAL(32'hA5A5A5A5)) u_b (
      .clk_i(clk), .rst_i(rst), .data_i(db), .select_i(sel[1:0]), .valid_i(valid),
      .stall_i(stall), .flush_i(flush), .data_o(ob), .valid_o(vb), .sel_err_o(eb));
   mux_reg_n #(.WIDTH(32), .NUM_IN(3), .DEPTH(2), .RESET_VAL(32'h13)) u_c (
      .clk_i(clk), .rst_i(rst), .data_i(dc), .select_i(sel[1:0]), .valid_i(valid),
      .stall_i(stall), .flush_i(flush), .data_o(oc), .valid_o(vc), .sel_err_o(ec));
   mux_reg_n #(.WIDTH(64), .NUM_IN(16), .DEPTH(4), .RESET_VAL(64'hFFFF0000FFFF0000)) u_d (
      .clk_i(clk), .rst_i(rst), .data_i(dd), .select_i(sel), .valid_i(valid),
      .stall_i(stall), .flush_i(flush), .data_o(od), .valid_o(vd), .sel_err_o(ed));

   function automatic logic [63:0] exp_d(int i);
      return m_d[i][cfg_depth[i]-1];
   endfunction
   function automatic logic exp_v(int i);
      return m_v[i][cfg_depth[i]-1];
   endfunction
   function automatic logic exp_e(int i);
      return m_e[i][cfg_depth[i]-1];
   endfunction

   task automatic model_edge();
      int          s_eff;
      logic [63:0] nd, mask;
      bit          ne;
      for (int i = 0; i < 4; i++) begin
         if (rst || flush) begin
            for (int s = 0; s < 4; s++) begin
               m_d[i][s] = cfg_rv[i]; m_v[i][s] = 0; m_e[i][s] = 0;
            end
         end else if (!stall) begin
            mask  = (cfg_w[i] == 64) ? 64'hFFFFFFFFFFFFFFFF : 64'hFFFFFFFF;
            s_eff = int'(sel) % (1 << cfg_selw[i]);
            if (s_eff < cfg_num[i]) begin
               nd = in_word[s_eff] & mask; ne = 0;
            end else begin
               nd = cfg_rv[i]; ne = valid;
            end
            for (int s = 3; s > 0; s--) begin
               m_d[i][s] = m_d[i][s-1]; m_v[i][s] = m_v[i][s-1]; m_e[i][s] = m_e[i][s-1];
            end
            m_d[i][0] = nd; m_v[i][0] = valid; m_e[i][0] = ne;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      rst = 0; valid = 0; stall = 0; flush = 0; sel = 0;
   endtask

   task automatic test_reset();
      rst = 1; valid = 1; sel = 1; stall = 0; flush = 0;
      for (int k = 0; k < 16; k++) in_word[k] = {$urandom, $urandom};
      for (int c = 0; c < 2; c++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_d[i] !== cfg_rv[i] || obs_v[i] !== 1'b0 || obs_e[i] !== 1'b0) begin
               bad++;
               $display("FAIL reset inst%0d: got d=%h v=%b e=%b want d=%h v=0 e=0",
                        i, obs_d[i], obs_v[i], obs_e[i], cfg_rv[i]);
            end
         end
      end
      idle();
   endtask

   task automatic test_basic_select();
      logic [31:0] want;
      for (int k = 0; k < 4; k++) in_word[k] = {2{32'(32'h11111111 * 32'(k + 1))}};
      for (int k = 0; k < 4; k++) begin
         sel = 4'(k); valid = 1;
         tick();
         want = 32'h11111111 * 32'(k + 1);
         total++;
         if (oa !== want || va !== 1'b1) begin
            bad++;
            $display("FAIL basic_select sel=%0d: got d=%h v=%b want d=%h v=1", k, oa, va, want);
         end
         for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_d[i] !== exp_d(i) || obs_v[i] !== exp_v(i) || obs_e[i] !== exp_e(i)) begin
               bad++;
               $display("FAIL basic_model inst%0d: got d=%h v=%b e=%b want d=%h v=%b e=%b",
                        i, obs_d[i], obs_v[i], obs_e[i], exp_d(i), exp_v(i), exp_e(i));
            end
         end
      end
      idle();
   endtask

   task automatic test_depth_stall();
      logic [31:0] a_val, b_val;
      a_val = in_word[0][31:0];
      b_val = in_word[1][31:0];
      for (int k = 0; k < 3; k++) begin
         sel = 4'(k); valid = 1;
         tick();
      end
      total++;
      if (ob !== a_val || vb !== 1'b1) begin
         bad++;
         $display("FAIL depth3_latency: got d=%h v=%b want d=%h v=1", ob, vb, a_val);
      end
      stall = 1;
      for (int c = 0; c < 2; c++) begin
         sel = 4'($urandom_range(0, 15)); valid = 1;
         for (int k = 0; k < 16; k++) in_word[k] = {$urandom, $urandom};
         tick();
         total++;
         if (ob !== a_val || vb !== 1'b1) begin
            bad++;
            $display("FAIL stall_freeze c=%0d: got d=%h v=%b want d=%h v=1", c, ob, vb, a_val);
         end
         for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_d[i] !== exp_d(i) || obs_v[i] !== exp_v(i) || obs_e[i] !== exp_e(i)) begin
               bad++;
               $display("FAIL stall_model inst%0d: got d=%h v=%b e=%b want d=%h v=%b e=%b",
                        i, obs_d[i], obs_v[i], obs_e[i], exp_d(i), exp_v(i), exp_e(i));
            end
         end
      end
      stall = 0; valid = 0;
      tick();
      total++;
      if (ob !== b_val || vb !== 1'b1) begin
         bad++;
         $display("FAIL stall_resume: got d=%h v=%b want d=%h v=1", ob, vb, b_val);
      end
      idle();
   endtask

   task automatic test_flush();
      logic [31:0] c_val;
      for (int k = 0; k < 16; k++) in_word[k] = {$urandom, $urandom};
      c_val = in_word[2][31:0];
      sel = 0; valid = 1; tick();
      sel = 1; valid = 1; tick();
      sel = 2; valid = 1; flush = 1; stall = 1;
      tick();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (obs_d[i] !== cfg_rv[i] || obs_v[i] !== 1'b0 || obs_e[i] !== 1'b0) begin
            bad++;
            $display("FAIL flush inst%0d: got d=%h v=%b e=%b want d=%h v=0 e=0",
                     i, obs_d[i], obs_v[i], obs_e[i], cfg_rv[i]);
         end
      end
      flush = 0; stall = 0; sel = 2; valid = 1;
      tick();
      valid = 0; sel = 0;
      tick();
      total++;
      if (oc !== c_val || vc !== 1'b1) begin
         bad++;
         $display("FAIL flush_next_entry: got d=%h v=%b want d=%h v=1", oc, vc, c_val);
      end
      idle();
   endtask

   task automatic test_out_of_range();
      for (int k = 0; k < 16; k++) in_word[k] = {$urandom, $urandom};
      sel = 3; valid = 1; tick();
      sel = 0; valid = 1; tick();
      total++;
      if (oc !== 32'h13 || vc !== 1'b1 || ec !== 1'b1) begin
         bad++;
         $display("FAIL oor_err: got d=%h v=%b e=%b want d=00000013 v=1 e=1", oc, vc, ec);
      end
      total++;
      if (ea !== 1'b0 || eb !== 1'b0 || ed !== 1'b0) begin
         bad++;
         $display("FAIL oor_dense_err: got a=%b b=%b d=%b want all 0", ea, eb, ed);
      end
      sel = 1; valid = 1; tick();
      total++;
      if (oc !== in_word[0][31:0] || vc !== 1'b1 || ec !== 1'b0) begin
         bad++;
         $display("FAIL oor_clear: got d=%h v=%b e=%b want d=%h v=1 e=0", oc, vc, ec, in_word[0][31:0]);
      end
      sel = 3; valid = 0; tick();
      tick();
      total++;
      if (vc !== 1'b0 || ec !== 1'b0) begin
         bad++;
         $display("FAIL oor_invalid: got v=%b e=%b want v=0 e=0", vc, ec);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 16; k++) in_word[k] = {$urandom, $urandom};
      for (int c = 0; c < 3; c++) begin
         sel = 4'($urandom_range(0, 2)); valid = 1; tick();
      end
      rst = 1; valid = 1; tick();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (obs_d[i] !== cfg_rv[i] || obs_v[i] !== 1'b0 || obs_e[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid inst%0d: got d=%h v=%b e=%b want d=%h v=0 e=0",
                     i, obs_d[i], obs_v[i], obs_e[i], cfg_rv[i]);
         end
      end
      rst = 0; sel = 0; valid = 1; tick();
      total++;
      if (oc !== 32'h13 || vc !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_hold: got d=%h v=%b want d=00000013 v=0", oc, vc);
      end
      valid = 0; tick();
      total++;
      if (oc !== in_word[0][31:0] || vc !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_refill: got d=%h v=%b want d=%h v=1", oc, vc, in_word[0][31:0]);
      end
      idle();
   endtask

   task automatic test_wide();
      logic [3:0]  nib;
      logic [63:0] want;
      for (int k = 0; k < 16; k++) begin
         nib = 4'(k);
         in_word[k] = {16{nib}};
      end
      for (int t = 0; t < 20; t++) begin
         sel = (t < 16) ? 4'(t) : 4'd0;
         valid = (t < 16);
         tick();
         if (t >= 3 && t < 19) begin
            nib  = 4'(t - 3);
            want = {16{nib}};
            total++;
            if (od !== want || vd !== 1'b1 || ed !== 1'b0) begin
               bad++;
               $display("FAIL wide k=%0d: got d=%h v=%b e=%b want d=%h v=1 e=0", t - 3, od, vd, ed, want);
            end
         end
      end
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 16; k++) in_word[k] = {$urandom, $urandom};
         sel   = 4'($urandom_range(0, 15));
         valid = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         tick();
         for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_d[i] !== exp_d(i) || obs_v[i] !== exp_v(i) || obs_e[i] !== exp_e(i)) begin
               bad++;
               $display("FAIL random c=%0d inst%0d: got d=%h v=%b e=%b want d=%h v=%b e=%b",
                        c, i, obs_d[i], obs_v[i], obs_e[i], exp_d(i), exp_v(i), exp_e(i));
            end
         end
      end
      idle();
   endtask

   initial begin
      idle();
      for (int k = 0; k < 16; k++) in_word[k] = '0;
      #2;
      test_reset();
      test_basic_select();
      test_depth_stall();
      test_flush();
      test_out_of_range();
      test_reset_mid();
      test_wide();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
